// File: rtl/alu_multicycle.sv
// alu_multicycle
// WIDTH-bit ALU for the multicycle CPU. Logic, arithmetic, shift and compare
// ops finish in a single cycle. Unsigned multiply, divide and remainder take
// WIDTH cycles, one shift-add or restoring-subtract step per cycle. The block
// takes requests and returns results over valid/ready handshakes, and it
// handles one operation at a time.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [3:0]         funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_result,
  output logic               zero,
  output logic               busy
);

  typedef enum logic [3:0] {
    F_ADD   = 4'd0,
    F_SUB   = 4'd1,
    F_AND   = 4'd2,
    F_OR    = 4'd3,
    F_XOR   = 4'd4,
    F_NOR   = 4'd5,
    F_SLL   = 4'd6,
    F_SRL   = 4'd7,
    F_SRA   = 4'd8,
    F_SLT   = 4'd9,
    F_SLTU  = 4'd10,
    F_MUL   = 4'd11,
    F_MULHU = 4'd12,
    F_DIVU  = 4'd13,
    F_REMU  = 4'd14,
    F_RSVD  = 4'd15
  } funct_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Iterative datapath. For multiply, {r_acc, r_mq} is the running product
  // and the multiplier shifts out of r_mq. For divide, r_acc is the partial
  // remainder and quotient bits shift into r_mq.
  logic [3:0]         r_funct;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH-1:0]   r_op2;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;

  logic               w_is_iter;
  logic [WIDTH-1:0]   w_single;
  logic               w_is_mul;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_mq_nxt;
  logic [WIDTH-1:0]   w_iter_result;

  assign w_is_iter  = funct inside {F_MUL, F_MULHU, F_DIVU, F_REMU};
  assign alu_result = r_result;
  assign zero       = r_zero;

  // Single-cycle result, computed from the live request operands so that it
  // can be registered on the handshake edge.
  // NOTE: every signal is given a default first, so no path through this
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_single = '0;
    case (funct)
      F_ADD:  w_single = operand1 + operand2;
      F_SUB:  w_single = operand1 - operand2;
      F_AND:  w_single = operand1 & operand2;
      F_OR:   w_single = operand1 | operand2;
      F_XOR:  w_single = operand1 ^ operand2;
      F_NOR:  w_single = ~(operand1 | operand2);
      F_SLL:  w_single = operand1 << shamt;
      F_SRL:  w_single = operand1 >> shamt;
      F_SRA:  w_single = $signed(operand1) >>> shamt;
      F_SLT:  w_single = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      F_SLTU: w_single = {{(WIDTH-1){1'b0}}, operand1 < operand2};
      default: w_single = '0;  // Reserved, plus iterative ops (not used here).
    endcase
  end

  // One multiply or divide step. When the divisor is zero, every trial
  // subtract succeeds. The quotient then becomes all ones and the remainder
  // becomes the dividend, with no special case needed.
  always_comb begin
    w_is_mul    = (r_funct == F_MUL) || (r_funct == F_MULHU);
    w_mul_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_op2} : '0);
    w_div_shift = {r_acc, r_mq[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_op2};
    w_acc_nxt   = '0;
    w_mq_nxt    = '0;
    if (w_is_mul) begin
      w_acc_nxt = w_mul_sum[WIDTH:1];
      w_mq_nxt  = {w_mul_sum[0], r_mq[WIDTH-1:1]};
    end else if (w_div_diff[WIDTH]) begin
      // Borrow: the divisor does not fit, so restore the shifted remainder.
      w_acc_nxt = w_div_shift[WIDTH-1:0];
      w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b0};
    end else begin
      w_acc_nxt = w_div_diff[WIDTH-1:0];
      w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b1};
    end
    w_iter_result = ((r_funct == F_MUL) || (r_funct == F_DIVU)) ? w_mq_nxt : w_acc_nxt;
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, hold in DONE until consumed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)       w_state_nxt = w_is_iter ? ST_BUSY : ST_DONE;
      ST_BUSY: if (r_cnt == '0)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)      w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_BUSY: busy      = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath. Capture the request on the handshake, step the iteration,
  // then register the result and its zero flag together.
  // NOTE: the datapath registers are reset as well. A reset in mid-operation
  // then leaves no leftover partial product or remainder to show up later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_funct  <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_op2    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_funct <= funct;
            r_acc   <= '0;
            r_mq    <= operand1;
            r_op2   <= operand2;
            r_cnt   <= SHAMT_W'(WIDTH - 1);
            if (!w_is_iter) begin
              r_result <= w_single;
              r_zero   <= (w_single == '0);
            end
          end
        end
        ST_BUSY: begin
          r_acc <= w_acc_nxt;
          r_mq  <= w_mq_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_result <= w_iter_result;
            r_zero   <= (w_iter_result == '0);
          end
        end
        default: ;  // DONE holds the result until it is consumed.
      endcase
    end
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle combinational ALU: same operand1/operand2/shamt/funct operand set, generalised to WIDTH bits.
- Adds iterative unsigned multiply/divide ops, a registered result and valid/ready handshakes on both sides.
- Sits between the decode/issue stage and writeback of the multicycle CPU; the issue stage stalls on in_ready=0.

Parameters:
- WIDTH, 32, operand/result width; legal values are powers of two, 8..64.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- operand1  input  WIDTH  first operand
- operand2  input  WIDTH  second operand
- shamt  input  SHAMT_W  shift amount
- funct  input  4  operation select
- out_valid  output  1  alu_result valid
- out_ready  input  1  consumer accepts result
- alu_result  output  WIDTH  registered result
- zero  output  1  alu_result == 0, registered with alu_result
- busy  output  1  iterative op in progress

Behaviour:
- Reset, asynchronous on reset_n=0:
  - state=IDLE; in_ready=1; out_valid=0; alu_result=0; zero=1; busy=0.
  - A reset mid-operation abandons the op; no result is produced.
- Funct encoding:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
  - 0110 SLL (operand1<<shamt); 0111 SRL; 1000 SRA (arithmetic, sign of operand1).
  - 1001 SLT (signed, result 1/0); 1010 SLTU.
  - 1011 MUL (low WIDTH bits of unsigned product); 1100 MULHU (high WIDTH bits).
  - 1101 DIVU (quotient); 1110 REMU (remainder).
  - 1111 reserved: result 0, single-cycle path.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- States:
  - IDLE: in_ready=1. Handshake occurs when in_valid & in_ready at a rising edge. Operands and funct are captured at that edge; the inputs may change afterwards.
    - Single-cycle funct (0000-1010, 1111): the result is computed and registered at the same edge -> DONE. out_valid=1 on the next cycle (latency 1).
    - Iterative funct (1011-1110): -> BUSY, counter=WIDTH-1, busy=1.
  - BUSY: in_ready=0, out_valid=0.
    - One shift-add (MUL/MULHU) or restoring-subtract (DIVU/REMU) step per cycle, WIDTH steps total.
    - On the cycle counter==0 the final result is registered -> DONE.
    - out_valid rises exactly WIDTH cycles after the handshake edge, e.g. 32 for WIDTH=32.
  - DONE: out_valid=1, in_ready=0. alu_result and zero are held stable until out_valid & out_ready at an edge, then -> IDLE and out_valid=0.
- No back-to-back overlap: the earliest next accept is the cycle after the result is consumed.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Divide by zero, when operand2==0:
  - DIVU returns all ones; REMU returns operand1.
  - The op still takes the full WIDTH cycles, keeping latency data-independent.
- MULHU/DIVU/REMU with operand1=0 also take the full latency.
- busy=1 only in BUSY.
- zero is derived from the value being registered into alu_result, so it is never one cycle stale.

Test Plan:
- Reset mid-op: issue DIVU, assert reset_n=0 at cycle 10 of BUSY -> out_valid=0, in_ready=1, alu_result=0 immediately (asynchronous). The next ADD completes normally.
- Single-cycle sweep, WIDTH=32:
  - ADD 0xFFFFFFFF+1 -> 0x00000000, zero=1.
  - SUB 5-7 -> 0xFFFFFFFE.
  - SRA 0x80000000 shamt=4 -> 0xF8000000.
  - SLT 0xFFFFFFFF,1 -> 1; SLTU of the same -> 0.
  - Each out_valid appears exactly 1 cycle after the handshake.
- Multiply: MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU of the same -> 0xFFFFFFFE. out_valid exactly 32 cycles after the handshake; busy=1 throughout BUSY.
- Divide:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU x/0 -> 0x12345678, with the full 32-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after DONE while in_valid=1 with new operands -> alu_result stable, in_ready=0, no new capture. Release -> the result is consumed, then the new request is accepted the following cycle.
- Parametrisation: rerun the sweep with WIDTH=8, SHAMT_W=3. MUL 0xFF*0xFF -> 0x01, MULHU -> 0xFE, with an 8-cycle latency. Results are compared against a golden model from .mem files, with the bench reporting a PASSED/FAILED count.
